wash_controller: RTL
====================

# wash_controller

Top-level sequencing FSM for the washing machine. It owns the machine state and the 26-bit stage-time vector `msg`, loads per-mode programme presets, and counts the active stage down once per time tick. It drives the water valves, motor and buzzer. Its `state` and `msg` outputs feed the display/LED view block directly, using the same state codes and field layout.

## Interface
- `TICK_DIV`, 50_000_000, `cp` cycles per time unit (1 s at 50 MHz).
- `FINISH_TICKS`, 5, time units the buzzer sounds in `finishST` before the automatic return to `beginST`.
- `IDLE_TICKS`, 30, idle time units before auto power-off (only with `WASH_AUTO_OFF_EN`).
- `cp`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `powerBtn`  in  1  single-cycle pulse, debounced upstream.
- `startBtn`  in  1  single-cycle pulse; start/pause toggle.
- `modeBtn`  in  1  single-cycle pulse; programme select.
- `doorOpen`  in  1  level; door sensor.
- `state`  out  3  0 shutDownST, 1 beginST, 2 setST, 3 runST, 4 errorST, 5 pauseST, 6 finishST.
- `msg`  out  26  stage remaining times. Execution order is f7 first, f0 last:
  - f7 [25:23] fill
  - f6 [22:19] wash
  - f5 [18:16] drain
  - f4 [15:13] fill
  - f3 [12:10] rinse
  - f2 [9:6] spin
  - f1 [5:3] drain
  - f0 [2:0] final spin
- `mode`  out  2  selected programme.
- `valveIn`, `valveOut`, `motorOn`, `buzzer`  out  1 each  actuators.

## Operation
- Reset: `state`=0, `msg`=0, `mode`=0, all actuators 0, prescaler and counters 0.
- Active stage is the highest-numbered nonzero field.
  - Fill stages assert `valveIn`.
  - Drain stages assert `valveOut`.
  - Wash, rinse and spin stages assert `motorOn`.
  - Actuators are asserted only in `runST`.
- `buzzer` = 1 in `errorST`, and in `finishST` while its counter is running.
- Presets, per field f7..f0:
  - mode0 standard: 2,9,2,2,4,6,2,3
  - mode1 quick: 1,4,1,1,2,3,1,2
  - mode2 heavy: 3,15,3,3,7,15,3,7
  - mode3 spin-only: 0,0,0,0,0,10,2,5
- `powerBtn` in any state other than shutDownST → shutDownST, `msg`=0, `mode` unchanged. This has the highest priority over all other events in the same cycle.
- shutDownST: `powerBtn` → beginST, `msg` loaded with the preset of `mode`.
- beginST, modeBtn: `mode` ← `mode`+1 (wraps 3→0), `msg` reloaded, → setST.
- beginST, startBtn: `doorOpen` → errorST; otherwise → runST.
- setST: same as beginST, but `modeBtn` stays in setST.
- runST: `doorOpen` → errorST, and a tick in the same cycle is discarded. Else `startBtn` → pauseST. Else on tick, decrement the active field by 1; if `msg` becomes all-zero → finishST with the finish counter loaded with `FINISH_TICKS`.
- errorST: when `doorOpen` falls → pauseST. No automatic resume.
- pauseST: `startBtn` with `doorOpen`=0 → runST. `startBtn` with `doorOpen`=1 is ignored.
- finishST: the counter decrements per tick; at 0 → beginST with `msg` reloaded. `startBtn` or `modeBtn` → beginST immediately.
- Field arithmetic is unsigned and confined to the field's width; borrow never propagates between fields.

## Timing
- Prescaler counts 0..`TICK_DIV`-1 and free-runs in every state except shutDownST, where it is held at 0. The tick is a one-cycle pulse when the count reaches `TICK_DIV`-1.
- Button and tick effects appear on `state`/`msg` at the next `cp` edge, i.e. 1-cycle latency.
- Actuators are combinational decodes of the registered `state` and `msg`, with no added latency.
- Reset asserted mid-run forces reset values asynchronously; after release the block waits for `powerBtn`.

## Configuration
- `WASH_AUTO_OFF_EN` defined: an idle counter counts ticks in beginST, setST and pauseST.
  - It clears on any button pulse and on any state change.
  - When it reaches `IDLE_TICKS` → shutDownST, `msg`=0.
- `WASH_AUTO_OFF_EN` undefined: no idle counter; the block stays in those states indefinitely.

## Structure
- Shared package `wash_pkg`:
  - state code localparams
  - field MSB/LSB constants
  - the four preset vectors
  - the active-stage→actuator mapping
- Sub-module `tick_gen` (prescaler with `TICK_DIV` and a hold input) generates the tick.

## Test plan
All scenarios use `TICK_DIV`=4 and `FINISH_TICKS`=2.
- Reset, then `powerBtn` → `state`=1, `msg` = mode0 preset (f6=9), `valveIn`=0.
- `modeBtn` ×2 → `state`=2, `mode`=2, f6=15; a third press loads mode3 with f7..f3=0.
- Start mode1, run for 4 ticks → f7 reaches 0 after 1 tick, then `motorOn`=1 and f6 counts 4→1; the sum of fields decreases by 1 per tick.
- `doorOpen` in runST on the same cycle as a tick → errorST with `msg` unchanged and `buzzer`=1. Door closed → pauseST. `startBtn` → runST.
- mode3 run to completion, 17 ticks → finishST with `buzzer`=1, then beginST 2 ticks later with f2=10 reloaded.
- `powerBtn` and `startBtn` in the same cycle during pauseST → shutDownST with `msg`=0. With `WASH_AUTO_OFF_EN` and `IDLE_TICKS`=3, beginST idle for 3 ticks → `state`=0.

Source files
------------

// File: rtl/wash_pkg.sv
// Shared definitions for the washing-machine sequencer: state codes, stage-field
// layout of the 26-bit msg vector, programme presets and stage-to-actuator decode.
package wash_pkg;

    typedef enum logic [2:0] {
        SHUTDOWN_ST = 3'd0,
        BEGIN_ST    = 3'd1,
        SET_ST      = 3'd2,
        RUN_ST      = 3'd3,
        ERROR_ST    = 3'd4,
        PAUSE_ST    = 3'd5,
        FINISH_ST   = 3'd6
    } state_e;

    // Stage fields, executed f7 first down to f0.
    localparam int F7_MSB = 25, F7_LSB = 23;  // fill
    localparam int F6_MSB = 22, F6_LSB = 19;  // wash
    localparam int F5_MSB = 18, F5_LSB = 16;  // drain
    localparam int F4_MSB = 15, F4_LSB = 13;  // fill
    localparam int F3_MSB = 12, F3_LSB = 10;  // rinse
    localparam int F2_MSB = 9,  F2_LSB = 6;   // spin
    localparam int F1_MSB = 5,  F1_LSB = 3;   // drain
    localparam int F0_MSB = 2,  F0_LSB = 0;   // final spin

    localparam logic [25:0] PRESET_STANDARD = {3'd2, 4'd9,  3'd2, 3'd2, 3'd4, 4'd6,  3'd2, 3'd3};
    localparam logic [25:0] PRESET_QUICK    = {3'd1, 4'd4,  3'd1, 3'd1, 3'd2, 4'd3,  3'd1, 3'd2};
    localparam logic [25:0] PRESET_HEAVY    = {3'd3, 4'd15, 3'd3, 3'd3, 3'd7, 4'd15, 3'd3, 3'd7};
    localparam logic [25:0] PRESET_SPIN     = {3'd0, 4'd0,  3'd0, 3'd0, 3'd0, 4'd10, 3'd2, 3'd5};

    typedef struct packed {
        logic valve_in;
        logic valve_out;
        logic motor_on;
    } act_t;

    function automatic logic [25:0] preset(input logic [1:0] m);
        logic [25:0] p;
        case (m)
            2'd0:    p = PRESET_STANDARD;
            2'd1:    p = PRESET_QUICK;
            2'd2:    p = PRESET_HEAVY;
            default: p = PRESET_SPIN;
        endcase
        return p;
    endfunction

    // The active stage is the highest-numbered nonzero field.
    function automatic act_t stage_act(input logic [25:0] m);
        act_t a;
        a = '0;
        if      (|m[F7_MSB:F7_LSB]) a.valve_in  = 1'b1;
        else if (|m[F6_MSB:F6_LSB]) a.motor_on  = 1'b1;
        else if (|m[F5_MSB:F5_LSB]) a.valve_out = 1'b1;
        else if (|m[F4_MSB:F4_LSB]) a.valve_in  = 1'b1;
        else if (|m[F3_MSB:F3_LSB]) a.motor_on  = 1'b1;
        else if (|m[F2_MSB:F2_LSB]) a.motor_on  = 1'b1;
        else if (|m[F1_MSB:F1_LSB]) a.valve_out = 1'b1;
        else if (|m[F0_MSB:F0_LSB]) a.motor_on  = 1'b1;
        return a;
    endfunction

    // Each field is decremented within its own width so no borrow crosses fields.
    function automatic logic [25:0] dec_active(input logic [25:0] m);
        logic [25:0] r;
        r = m;
        if      (|m[F7_MSB:F7_LSB]) r[F7_MSB:F7_LSB] = m[F7_MSB:F7_LSB] - 3'd1;
        else if (|m[F6_MSB:F6_LSB]) r[F6_MSB:F6_LSB] = m[F6_MSB:F6_LSB] - 4'd1;
        else if (|m[F5_MSB:F5_LSB]) r[F5_MSB:F5_LSB] = m[F5_MSB:F5_LSB] - 3'd1;
        else if (|m[F4_MSB:F4_LSB]) r[F4_MSB:F4_LSB] = m[F4_MSB:F4_LSB] - 3'd1;
        else if (|m[F3_MSB:F3_LSB]) r[F3_MSB:F3_LSB] = m[F3_MSB:F3_LSB] - 3'd1;
        else if (|m[F2_MSB:F2_LSB]) r[F2_MSB:F2_LSB] = m[F2_MSB:F2_LSB] - 4'd1;
        else if (|m[F1_MSB:F1_LSB]) r[F1_MSB:F1_LSB] = m[F1_MSB:F1_LSB] - 3'd1;
        else if (|m[F0_MSB:F0_LSB]) r[F0_MSB:F0_LSB] = m[F0_MSB:F0_LSB] - 3'd1;
        return r;
    endfunction

endpackage

// File: rtl/wash_tick_gen.sv
// Time-unit prescaler: free-running 0..TICK_DIV-1 counter with a one-cycle tick
// on the last count; hold_i parks it at zero.
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic cp,
    input  logic rst,
    input  logic hold_i,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (hold_i || count_q == LAST) count_d = '0;
        else                           count_d = count_q + CW'(1);
    end

    always_ff @(posedge cp or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign tick_o = !hold_i && (count_q == LAST);

endmodule

// File: rtl/wash_controller.sv
// Washing-machine sequencing FSM: owns state, mode and the stage-time vector msg.
// Optional idle auto power-off is built when WASH_AUTO_OFF_EN is defined.
module wash_controller
    import wash_pkg::*;
#(
    parameter int TICK_DIV     = 50_000_000,
    parameter int FINISH_TICKS = 5,
    parameter int IDLE_TICKS   = 30
) (
    input  logic        cp,
    input  logic        rst,
    input  logic        powerBtn,
    input  logic        startBtn,
    input  logic        modeBtn,
    input  logic        doorOpen,
    output logic [2:0]  state,
    output logic [25:0] msg,
    output logic [1:0]  mode,
    output logic        valveIn,
    output logic        valveOut,
    output logic        motorOn,
    output logic        buzzer
);

    localparam int FW = (FINISH_TICKS > 0) ? $clog2(FINISH_TICKS + 1) : 1;

    // Non-positive timing parameters have no meaningful behaviour; this block only flags them by name.
    if (TICK_DIV < 1 || FINISH_TICKS < 1 || IDLE_TICKS < 1) begin : g_invalid_params
    end

    state_e        state_q, state_d;
    logic [25:0]   msg_q, msg_d;
    logic [1:0]    mode_q, mode_d;
    logic [FW-1:0] fin_q, fin_d;
    logic          tick;
    logic [25:0]   msg_dec;
    act_t          act;

`ifdef WASH_AUTO_OFF_EN
    localparam int IW = $clog2(IDLE_TICKS + 1);
    logic [IW-1:0] idle_q, idle_d;
    logic          idle_hold;
`endif

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .cp     (cp),
        .rst    (rst),
        .hold_i (state_q == SHUTDOWN_ST),
        .tick_o (tick)
    );

    assign msg_dec = dec_active(msg_q);

    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        mode_d  = mode_q;
        fin_d   = fin_q;
        if (powerBtn && state_q != SHUTDOWN_ST) begin
            state_d = SHUTDOWN_ST;
            msg_d   = '0;
            fin_d   = '0;
        end else begin
            case (state_q)
                SHUTDOWN_ST: begin
                    if (powerBtn) begin
                        state_d = BEGIN_ST;
                        msg_d   = preset(mode_q);
                    end
                end
                BEGIN_ST, SET_ST: begin
                    // Mode selection wins over start when both arrive together.
                    if (modeBtn) begin
                        mode_d  = mode_q + 2'd1;
                        msg_d   = preset(mode_q + 2'd1);
                        state_d = SET_ST;
                    end else if (startBtn) begin
                        state_d = doorOpen ? ERROR_ST : RUN_ST;
                    end
                end
                RUN_ST: begin
                    if (doorOpen) begin
                        state_d = ERROR_ST;
                    end else if (startBtn) begin
                        state_d = PAUSE_ST;
                    end else if (tick) begin
                        msg_d = msg_dec;
                        if (msg_dec == '0) begin
                            state_d = FINISH_ST;
                            fin_d   = FW'(FINISH_TICKS);
                        end
                    end
                end
                ERROR_ST: begin
                    if (!doorOpen) state_d = PAUSE_ST;
                end
                PAUSE_ST: begin
                    if (startBtn && !doorOpen) state_d = RUN_ST;
                end
                FINISH_ST: begin
                    if (startBtn || modeBtn || (tick && fin_q <= FW'(1))) begin
                        state_d = BEGIN_ST;
                        msg_d   = preset(mode_q);
                        fin_d   = '0;
                    end else if (tick) begin
                        fin_d = fin_q - FW'(1);
                    end
                end
                default: begin
                    state_d = SHUTDOWN_ST;
                    msg_d   = '0;
                end
            endcase
        end

`ifdef WASH_AUTO_OFF_EN
        idle_d    = idle_q;
        idle_hold = (state_q == BEGIN_ST || state_q == SET_ST || state_q == PAUSE_ST) &&
                    (state_d == state_q) && !(powerBtn || startBtn || modeBtn);
        if (!idle_hold) begin
            idle_d = '0;
        end else if (tick) begin
            if (idle_q == IW'(IDLE_TICKS - 1)) begin
                state_d = SHUTDOWN_ST;
                msg_d   = '0;
                idle_d  = '0;
            end else begin
                idle_d = idle_q + IW'(1);
            end
        end
`endif
    end

    always_ff @(posedge cp or posedge rst) begin
        if (rst) begin
            state_q <= SHUTDOWN_ST;
            msg_q   <= '0;
            mode_q  <= '0;
            fin_q   <= '0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            mode_q  <= mode_d;
            fin_q   <= fin_d;
        end
    end

`ifdef WASH_AUTO_OFF_EN
    always_ff @(posedge cp or posedge rst) begin
        if (rst) idle_q <= '0;
        else     idle_q <= idle_d;
    end
`endif

    assign act      = stage_act(msg_q);
    assign state    = state_q;
    assign msg      = msg_q;
    assign mode     = mode_q;
    assign valveIn  = (state_q == RUN_ST) && act.valve_in;
    assign valveOut = (state_q == RUN_ST) && act.valve_out;
    assign motorOn  = (state_q == RUN_ST) && act.motor_on;
    assign buzzer   = (state_q == ERROR_ST) || (state_q == FINISH_ST && fin_q != '0);

endmodule
